// File: rtl/pwm_controller_multi.sv
// Multi-channel PWM core: one prescaled timebase (edge or center aligned)
// shared by NUM_CH compare channels with shadowed, boundary-committed config.
//
// Ports:
//   clk, reset (async, active-low)
//   period, prescaler, center_mode  - timebase configuration (shadowed)
//   timer_enable, update_req        - run control and shadow reload request
//   ch_enable, ch_polarity, ch_duty - per-channel config (duty is shadowed)
//   pwm_out                         - registered per-channel outputs
//   period_complete, timer_overflow - one-clock status pulses
//   update_pending                  - reload requested, not yet committed
module pwm_controller_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        period,
    input  logic [PRESC_W-1:0]      prescaler,
    input  logic                    timer_enable,
    input  logic                    center_mode,
    input  logic                    update_req,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       ch_polarity,
    input  logic [NUM_CH*CNT_W-1:0] ch_duty,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_complete,
    output logic                    timer_overflow,
    output logic                    update_pending
);

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_down;
    logic [CNT_W-1:0]   r_period_sh;
    logic [PRESC_W-1:0] r_presc_sh;
    logic               r_mode_sh;
    logic [CNT_W-1:0]   r_duty_sh [NUM_CH];
    logic               r_pending;
    logic [NUM_CH-1:0]  r_pwm;
    logic               r_pc;
    logic               r_ovf;

    logic               w_tick;
    logic               w_peak;
    logic               w_down;
    logic               w_bound;
    logic               w_load;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_down_nxt;
    logic [NUM_CH-1:0]  w_raw;
    logic [NUM_CH-1:0]  w_pwm_nxt;

    assign w_tick = timer_enable && (r_presc_cnt == r_presc_sh);
    assign w_peak = (r_cnt == r_period_sh);
    // The peak sample already belongs to the falling slope in center mode.
    assign w_down = r_down || w_peak;

    // Center boundary is the 1->0 step on the falling slope.
    assign w_bound = w_tick && (r_mode_sh
        ? ((r_period_sh == '0) || (w_down && (r_cnt == CNT_W'(1))))
        : w_peak);

    assign w_load = !timer_enable || (w_bound && (r_pending || update_req));

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_down_nxt = r_down;
        if (w_tick) begin
            if (!r_mode_sh) begin
                w_cnt_nxt  = w_peak ? '0 : r_cnt + CNT_W'(1);
                w_down_nxt = 1'b0;
            end else if (r_period_sh == '0) begin
                w_cnt_nxt  = '0;
                w_down_nxt = 1'b0;
            end else if (!w_down) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                w_down_nxt = (r_cnt != CNT_W'(1));
            end
        end
    end

    // In center mode the falling slope compares one count lower, so the
    // active time is 2*duty ticks, symmetric about the peak, and
    // duty >= period gives a fully active output.
    always_comb begin
        w_raw     = '0;
        w_pwm_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!r_mode_sh) begin
                w_raw[i] = (r_cnt < r_duty_sh[i]);
            end else begin
                w_raw[i] = (r_duty_sh[i] != '0) &&
                           (w_down ? (r_cnt <= r_duty_sh[i])
                                   : (r_cnt <  r_duty_sh[i]));
            end
            w_pwm_nxt[i] = (timer_enable && ch_enable[i])
                         ? (w_raw[i] ^ ch_polarity[i])
                         : ch_polarity[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc_cnt <= '0;
            r_cnt       <= '0;
            r_down      <= 1'b0;
            r_period_sh <= '0;
            r_presc_sh  <= '0;
            r_mode_sh   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i] <= '0;
            end
            r_pending <= 1'b0;
            r_pwm     <= '0;
            r_pc      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (!timer_enable) begin
                r_presc_cnt <= '0;
                r_cnt       <= '0;
                r_down      <= 1'b0;
            end else begin
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_W'(1);
                r_cnt       <= w_cnt_nxt;
                r_down      <= w_down_nxt;
            end

            if (w_load) begin
                r_period_sh <= period;
                r_presc_sh  <= prescaler;
                r_mode_sh   <= center_mode;
                for (int i = 0; i < NUM_CH; i++) begin
                    r_duty_sh[i] <= ch_duty[i*CNT_W +: CNT_W];
                end
            end

            if (w_load) begin
                r_pending <= 1'b0;
            end else if (update_req) begin
                r_pending <= 1'b1;
            end

            r_pwm <= w_pwm_nxt;
            r_pc  <= w_bound;
            r_ovf <= w_bound && !r_mode_sh && (&r_period_sh);
        end
    end

    assign pwm_out         = r_pwm;
    assign period_complete = r_pc;
    assign timer_overflow  = r_ovf;
    assign update_pending  = r_pending;

endmodule

// File: tb/tb_pwm_controller_multi.sv
// Bench for pwm_controller_multi: per-period window measurements are
// checked against hand-computed expectations queued by the stimulus.
module tb_pwm_controller_multi;

    logic        clk;
    logic        reset;
    logic [7:0]  period;
    logic [7:0]  prescaler;
    logic        timer_enable;
    logic        center_mode;
    logic        update_req;
    logic [3:0]  ch_enable;
    logic [3:0]  ch_polarity;
    logic [31:0] ch_duty;
    logic [3:0]  pwm_out;
    logic        period_complete;
    logic        timer_overflow;
    logic        update_pending;

    pwm_controller_multi #(
        .NUM_CH (4),
        .CNT_W  (8),
        .PRESC_W(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .period         (period),
        .prescaler      (prescaler),
        .timer_enable   (timer_enable),
        .center_mode    (center_mode),
        .update_req     (update_req),
        .ch_enable      (ch_enable),
        .ch_polarity    (ch_polarity),
        .ch_duty        (ch_duty),
        .pwm_out        (pwm_out),
        .period_complete(period_complete),
        .timer_overflow (timer_overflow),
        .update_pending (update_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int hi0;
        int hi1;
        int hi2;
        int ovf;
        int pend;
    } win_t;

    win_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: a window runs from one period_complete sample up to the next.
    initial begin
        bit   armed;
        win_t m;
        win_t e;
        armed = 0;
        m = '{0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (!reset || !timer_enable) begin
                armed = 0;
            end else if (period_complete) begin
                if (armed && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("win_len",  m.len,  e.len);
                    chk("win_hi0",  m.hi0,  e.hi0);
                    chk("win_hi1",  m.hi1,  e.hi1);
                    chk("win_hi2",  m.hi2,  e.hi2);
                    chk("win_ovf",  m.ovf,  e.ovf);
                    chk("win_pend", m.pend, e.pend);
                end
                armed = 1;
                m = '{0, 0, 0, 0, 0, 0};
            end
            if (armed) begin
                m.len++;
                m.hi0  += int'(pwm_out[0]);
                m.hi1  += int'(pwm_out[1]);
                m.hi2  += int'(pwm_out[2]);
                m.ovf  += int'(timer_overflow);
                m.pend += int'(update_pending);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_duty(input int ch, input int d);
        ch_duty[ch*8 +: 8] = 8'(d);
    endtask

    task automatic push(input int n, input win_t w);
        repeat (n) exp_q.push_back(w);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout_windows_left", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic restart();
        timer_enable = 1'b0;
        step(3);
        timer_enable = 1'b1;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int n;
        reset        = 1'b0;
        period       = 8'd9;
        prescaler    = 8'd0;
        timer_enable = 1'b0;
        center_mode  = 1'b0;
        update_req   = 1'b0;
        ch_enable    = 4'b0001;
        ch_polarity  = 4'b0100;
        ch_duty      = '0;
        set_duty(0, 3);

        step(2);
        chk("rst_pwm",  int'(pwm_out), 0);
        chk("rst_pc",   int'(period_complete), 0);
        chk("rst_ovf",  int'(timer_overflow), 0);
        chk("rst_pend", int'(update_pending), 0);

        reset = 1'b1;
        step(2);
        chk("disabled_pol", int'(pwm_out), 4);

        // Edge mode, period 9, duty 3: 3 high of 10.
        timer_enable = 1'b1;
        push(3, '{10, 3, 0, 10, 0, 0});
        wait_empty(200);

        // Mid-period duty change: old duty until the boundary.
        push(1, '{10, 3, 0, 10, 0, 5});
        push(2, '{10, 7, 0, 10, 0, 0});
        step(4);
        chk("pend_before_req", int'(update_pending), 0);
        set_duty(0, 7);
        update_req = 1'b1;
        step(1);
        update_req = 1'b0;
        chk("pend_after_req", int'(update_pending), 1);
        wait_empty(200);

        // Prescaler 3 stretches every phase by 4.
        timer_enable = 1'b0;
        prescaler = 8'd3;
        set_duty(0, 3);
        restart();
        push(2, '{40, 12, 0, 40, 0, 0});
        wait_empty(400);

        // Center mode, period 4, duty 2: 8 clocks, 4 high.
        timer_enable = 1'b0;
        prescaler   = 8'd0;
        period      = 8'd4;
        center_mode = 1'b1;
        set_duty(0, 2);
        restart();
        push(2, '{8, 4, 0, 8, 0, 0});
        wait_empty(200);

        // Full-range edge mode with duty extremes and inverted ch2.
        timer_enable = 1'b0;
        center_mode = 1'b0;
        period      = 8'd255;
        ch_enable   = 4'b0110;
        ch_polarity = 4'b0100;
        set_duty(1, 0);
        set_duty(2, 255);
        restart();
        push(2, '{256, 0, 0, 1, 1, 0});
        wait_empty(1000);

        // Reset mid-period with a pending update.
        timer_enable = 1'b0;
        period    = 8'd9;
        ch_enable = 4'b0001;
        set_duty(0, 3);
        restart();
        step(15);
        update_req = 1'b1;
        step(1);
        update_req = 1'b0;
        chk("pend_mid_run", int'(update_pending), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_pwm",  int'(pwm_out), 0);
        chk("async_rst_pend", int'(update_pending), 0);
        chk("async_rst_pc",   int'(period_complete), 0);
        timer_enable = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);
        chk("post_rst_pol",  int'(pwm_out), 4);
        chk("post_rst_pend", int'(update_pending), 0);
        timer_enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_complete && n < 50);
        chk("first_pc_latency", n, 10);
        push(2, '{10, 3, 0, 10, 0, 0});
        wait_empty(200);

        timer_enable = 1'b0;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
